xcalc_seq: RTL
==============

Name: xcalc_seq

Overview:
Sequencer for the calculator datapath on the picoVersat data bus. Accepts one coded 12-bit command word (operation plus two 4-bit two's-complement operands) from the CPU and runs it through decode and execute states. ADD/SUB/NEG take one execute cycle; MUL is a 4-iteration shift-add. The signed result and status flags are readable by the CPU, and a magnitude-plus-sign result is driven to the display decoder. The block is mapped behind one address-decoder select, with addr bit 0 choosing the command/result or status/ack register.

Parameters:
DATA_W, 32, CPU data bus width
NR_W, 4, operand width (two's complement)
RES_W, 8, result width (two's complement internally)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sel  in  1  select from address decoder
we  in  1  CPU write enable
addr  in  1  0 = command/result, 1 = status/ack
data_in  in  DATA_W  CPU write data
data_out  out  DATA_W  CPU read data, combinational, 0 when sel=0
busy  out  1  command in progress
done  out  1  result valid, sticky until ack or new command
err  out  1  invalid opcode, sticky like done
result_mag  out  RES_W  absolute value of result, to display
result_sgn  out  1  1 when result is negative, to display

Behaviour:
- Reset: the FSM goes to IDLE. busy, done, err, result_mag, result_sgn, the internal result and the drop flag are all 0. Reset mid-operation aborts the operation with no completion.
- Command write (sel & we & addr=0):
  - Accepted only in IDLE or DONE.
  - Latches op=data_in[11:8], A=data_in[7:4], B=data_in[3:0].
  - Clears done, err and drop.
  - A write in any other state is ignored and sets drop.
- Ack write (sel & we & addr=1 & data_in[0]=1) in DONE: clears done and err; FSM returns to IDLE. Ignored in other states.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 MUL: A*B
  - 3 NEG: -A
  - 4..15: error
- Width rules: operands are sign-extended to RES_W before use. The ranges are ADD -16..14, SUB -15..15, MUL -56..64 and NEG -7..8, so no overflow is possible.
- FSM:
  - IDLE: wait for a command; go to DECODE on accept.
  - DECODE (1 cycle): sign-extend operands and check op. Invalid op goes to DONE with err=1 and result=0. MUL goes to MUL, also loading multiplicand=|A|, multiplier=|B|, neg=A[3]^B[3], acc=0 and cnt=0. All other ops go to EXEC.
  - EXEC (1 cycle): compute result, then go to DONE.
  - MUL (4 cycles): if multiplier[0], acc += multiplicand; then multiplicand<<=1, multiplier>>=1, cnt++. Exit to FIX when cnt=3.
  - FIX (1 cycle): result = neg ? -acc : acc; go to DONE.
  - DONE: done=1; stay until ack (to IDLE) or new command (to DECODE).
- Latency, with the command accepted at edge N:
  - busy=1 from N+1 until the edge that enters DONE.
  - ADD/SUB/NEG: done=1 after edge N+3.
  - MUL: done=1 after edge N+7.
  - Error: done=1 and err=1 after edge N+2.
- Outputs are registered and updated on the edge entering DONE:
  - result_mag = |result|
  - result_sgn = result[RES_W-1]
  - Both hold until the next completion or reset.
- Read data:
  - addr=0: result sign-extended to DATA_W.
  - addr=1: {zeros, drop, err, done, busy} in bits [3:0].
  - Reads have no side effects.
- A new command accepted in DONE restarts the pipeline. Previous result outputs hold until the new command completes.

Test Plan:
- Write 0x034 (3+4) -> busy for 2 cycles, done after N+3, data_out(addr0)=0x00000007, result_mag=7, result_sgn=0.
- Write 0x125 (2-5) -> data_out=0xFFFFFFFD, result_mag=3, result_sgn=1; ack (addr1, data 1) -> status=0x0, FSM in IDLE.
- Write 0x297 (-7*7) -> done after N+7, data_out=0xFFFFFFCF, result_mag=49, result_sgn=1. Write 0x288 (-8*-8) -> data_out=0x00000040, result_mag=64, result_sgn=0.
- Write 0xA12 -> after N+2, status=0x6 (err, done), data_out(addr0)=0.
- Write 0x234 then 0x011 two cycles later -> second write dropped, final result=12, status=0xA (drop, done).
- Start 0x277, assert rst during MUL -> all outputs 0, status 0. A subsequent 0x011 -> result 2 with normal latency.

Source files
------------

// File: rtl/xcalc_seq.sv
// ---------------------------------------------------------------------------
// xcalc_seq
// Command sequencer for the calculator datapath on the picoVersat data bus.
// The CPU writes one coded command word {op[3:0], A[3:0], B[3:0]}. The block
// decodes it and executes it: ADD/SUB/NEG take one execute cycle, and MUL is
// a shift-add over the operand magnitudes with a final sign fix-up. The CPU
// can read back the signed result and the status flags. A magnitude-plus-sign
// copy of the result drives the display decoder.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   sel, we     address-decoder select and CPU write enable
//   addr        0 = command (write) / result (read)
//               1 = ack (write, bit 0) / status (read)
//   data_in     CPU write data
//   data_out    CPU read data (combinational, 0 when not selected)
//   busy        a command is in flight
//   done        result valid; sticky until ack or a new command
//   err         invalid opcode; sticky like done
//   result_mag  |result|, to the display
//   result_sgn  result sign, to the display
// ---------------------------------------------------------------------------
module xcalc_seq #(
  parameter int DATA_W = 32,
  parameter int NR_W   = 4,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [RES_W-1:0]  result_mag,
  output logic              result_sgn
);

  localparam int OP_W  = 4;
  localparam int CNT_W = (NR_W > 2) ? $clog2(NR_W) : 1;

  localparam logic [OP_W-1:0]  OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0]  OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0]  OP_MUL   = 4'd2;
  localparam logic [OP_W-1:0]  OP_NEG   = 4'd3;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR_W - 1);
  localparam logic [RES_W-1:0] RES_ZERO = {RES_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MUL    = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Sign-extend an operand to the result width.
  function automatic logic [RES_W-1:0] sext_nr(input logic [NR_W-1:0] v);
    return {{(RES_W-NR_W){v[NR_W-1]}}, v};
  endfunction

  // Two's-complement magnitude of a result-width value.
  function automatic logic [RES_W-1:0] abs_res(input logic [RES_W-1:0] v);
    logic [RES_W-1:0] r;
    if (v[RES_W-1]) begin
      r = ~v + RES_W'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [NR_W-1:0]   a_q, a_d;
  logic [NR_W-1:0]   b_q, b_d;
  logic              start_q, start_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [NR_W-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [RES_W-1:0]  mag_q, mag_d;
  logic              sgn_q, sgn_d;

  logic              cmd_wr_s;
  logic              ack_wr_s;
  logic              accept_s;
  logic              finish_s;
  logic [RES_W-1:0]  res_next_s;
  logic [RES_W-1:0]  a_ext_s;
  logic [RES_W-1:0]  b_ext_s;

  // Bus decode; a command waiting for DECODE (start_q) blocks a second one.
  always_comb begin
    cmd_wr_s = sel & we & ~addr;
    ack_wr_s = sel & we & addr & data_in[0];
    accept_s = cmd_wr_s & ((state_q == S_IDLE) | (state_q == S_DONE)) & ~start_q;
    a_ext_s  = sext_nr(a_q);
    b_ext_s  = sext_nr(b_q);
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    start_d    = 1'b0;
    result_d   = result_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    drop_d     = drop_q;
    mag_d      = mag_q;
    sgn_d      = sgn_q;
    finish_s   = 1'b0;
    res_next_s = RES_ZERO;

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (op_q > OP_NEG) begin
          err_d      = 1'b1;
          res_next_s = RES_ZERO;
          finish_s   = 1'b1;
        end else if (op_q == OP_MUL) begin
          // The multiply runs on magnitudes; the product sign is applied in FIX.
          mcand_d  = abs_res(a_ext_s);
          mplier_d = NR_W'(abs_res(b_ext_s));
          neg_d    = a_q[NR_W-1] ^ b_q[NR_W-1];
          acc_d    = RES_ZERO;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_MUL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  res_next_s = a_ext_s + b_ext_s;
          OP_SUB:  res_next_s = a_ext_s - b_ext_s;
          OP_NEG:  res_next_s = RES_ZERO - a_ext_s;
          default: res_next_s = RES_ZERO;
        endcase
        finish_s = 1'b1;
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = {mcand_q[RES_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[NR_W-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_MUL;
        end
      end
      S_FIX: begin
        if (neg_q) begin
          res_next_s = RES_ZERO - acc_q;
        end else begin
          res_next_s = acc_q;
        end
        finish_s = 1'b1;
      end
      S_DONE: begin
        // A pending new command wins over a (blocked) ack.
        if (start_q) begin
          state_d = S_DECODE;
        end else if (ack_wr_s) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result and display outputs change only on the edge entering DONE.
    if (finish_s) begin
      state_d  = S_DONE;
      done_d   = 1'b1;
      result_d = res_next_s;
      mag_d    = abs_res(res_next_s);
      sgn_d    = res_next_s[RES_W-1];
    end else begin
      result_d = result_q;
      mag_d    = mag_q;
      sgn_d    = sgn_q;
    end

    if (accept_s) begin
      op_d    = data_in[2*NR_W +: OP_W];
      a_d     = data_in[NR_W +: NR_W];
      b_d     = data_in[0 +: NR_W];
      start_d = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      drop_d  = 1'b0;
    end else if (cmd_wr_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end

    busy_d = (state_d == S_DECODE) || (state_d == S_EXEC) ||
             (state_d == S_MUL) || (state_d == S_FIX);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= {OP_W{1'b0}};
      a_q      <= {NR_W{1'b0}};
      b_q      <= {NR_W{1'b0}};
      start_q  <= 1'b0;
      result_q <= RES_ZERO;
      mcand_q  <= RES_ZERO;
      mplier_q <= {NR_W{1'b0}};
      neg_q    <= 1'b0;
      acc_q    <= RES_ZERO;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      mag_q    <= RES_ZERO;
      sgn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      start_q  <= start_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      mag_q    <= mag_d;
      sgn_q    <= sgn_d;
    end
  end

  // CPU read mux.
  always_comb begin
    data_out = {DATA_W{1'b0}};
    if (sel) begin
      if (addr) begin
        data_out = {{(DATA_W-4){1'b0}}, drop_q, err_q, done_q, busy_q};
      end else begin
        data_out = {{(DATA_W-RES_W){result_q[RES_W-1]}}, result_q};
      end
    end else begin
      data_out = {DATA_W{1'b0}};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result_mag = mag_q;
  assign result_sgn = sgn_q;

endmodule
